// File: rtl/calc_entry_ctrl.sv
// Keypad entry and sequencing controller for the calculator: operand entry, operator latch, add/sub/mul,
// optional restoring divide (built only when CALC_DIV_EN is defined) and registered display outputs.
module calc_entry_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int OPW        = 14,
    parameter int RESW       = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_valid,
    input  logic [4:0]      key_code,
    output logic [RESW-1:0] disp_value,
    output logic            disp_neg,
    output logic            err,
    output logic            busy,
    output logic [1:0]      op_code
);

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_CALC, S_RES, S_ERR} state_t;

    localparam int              FULL  = 10 ** (MAX_DIGITS - 1);
    localparam logic [RESW-1:0] OPMAX = RESW'(10 ** MAX_DIGITS - 1);
`ifdef CALC_DIV_EN
    localparam int         CNTW    = $clog2(OPW + 1);
    localparam logic [4:0] OP_LAST = 5'd13;
`else
    localparam logic [4:0] OP_LAST = 5'd12;
`endif

    state_t            state_q, state_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [RESW-1:0]   res_q, res_d;
    logic              neg_q, neg_d;
    logic [RESW-1:0]   disp_value_q, disp_value_d;
    logic              disp_neg_q, disp_neg_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
`ifdef CALC_DIV_EN
    logic [OPW-1:0]    quo_q, quo_d, rem_q, rem_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [OPW:0]      rem_sh;
`endif

    logic              key_ok, is_digit, is_op, is_eq, is_clear;
    logic [RESW-1:0]   a_w, b_w;

    // Append one decimal digit unless the operand already holds MAX_DIGITS digits.
    function automatic logic [OPW-1:0] push_digit(input logic [OPW-1:0] acc, input logic [3:0] d);
        if (acc >= OPW'(FULL)) return acc;
        return OPW'(32'(acc) * 32'd10 + 32'(d));
    endfunction

    always_comb begin
        key_ok   = key_valid && (key_code <= 5'd15);
        is_digit = key_ok && (key_code <= 5'd9);
        is_op    = key_ok && (key_code >= 5'd10) && (key_code <= OP_LAST);
        is_eq    = key_ok && (key_code == 5'd14);
        is_clear = key_ok && (key_code == 5'd15);
        a_w      = RESW'(a_q);
        b_w      = RESW'(b_q);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        neg_d   = neg_q;
`ifdef CALC_DIV_EN
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        rem_sh  = {rem_q, quo_q[OPW-1]};
`endif

        case (state_q)
            S_A: begin
                if (is_digit) a_d = push_digit(a_q, key_code[3:0]);
                else if (is_op) begin
                    op_d    = 2'(key_code - 5'd10);
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (is_digit) begin
                    b_d     = OPW'(key_code[3:0]);
                    state_d = S_B;
                end else if (is_op) op_d = 2'(key_code - 5'd10);
            end
            S_B: begin
                if (is_digit) b_d = push_digit(b_q, key_code[3:0]);
                else if (is_eq) begin
                    state_d = S_CALC;
`ifdef CALC_DIV_EN
                    quo_d = a_q;
                    rem_d = '0;
                    cnt_d = '0;
`endif
                end
            end
            S_CALC: begin
`ifdef CALC_DIV_EN
                if (op_q == 2'd3) begin
                    // Zero divisor is caught before any iteration runs.
                    if (cnt_q == '0 && b_q == '0) state_d = S_ERR;
                    else if (cnt_q == CNTW'(OPW)) begin
                        res_d   = RESW'(quo_q);
                        neg_d   = 1'b0;
                        state_d = S_RES;
                    end else begin
                        if (rem_sh >= {1'b0, b_q}) begin
                            rem_d = OPW'(rem_sh - {1'b0, b_q});
                            quo_d = {quo_q[OPW-2:0], 1'b1};
                        end else begin
                            rem_d = rem_sh[OPW-1:0];
                            quo_d = {quo_q[OPW-2:0], 1'b0};
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end else
`endif
                begin
                    case (op_q)
                        2'd0: begin res_d = a_w + b_w; neg_d = 1'b0; end
                        2'd1: begin
                            neg_d = (b_q > a_q);
                            res_d = (b_q > a_q) ? (b_w - a_w) : (a_w - b_w);
                        end
                        default: begin res_d = a_w * b_w; neg_d = 1'b0; end
                    endcase
                    state_d = S_RES;
                end
            end
            S_RES: begin
                if (is_digit) begin
                    a_d     = OPW'(key_code[3:0]);
                    state_d = S_A;
                end else if (is_op && !neg_q && res_q <= OPMAX) begin
                    a_d     = res_q[OPW-1:0];
                    op_d    = 2'(key_code - 5'd10);
                    state_d = S_OP;
                end
            end
            default: ;
        endcase

        if (is_clear) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = 2'd0;
            neg_d   = 1'b0;
        end

        // Outputs are derived from the next state so they register alongside it.
        case (state_d)
            S_A, S_OP:   disp_value_d = RESW'(a_d);
            S_B, S_CALC: disp_value_d = RESW'(b_d);
            S_RES:       disp_value_d = res_d;
            default:     disp_value_d = '0;
        endcase
        disp_neg_d = (state_d == S_RES) && neg_d;
        busy_d     = (state_d == S_CALC);
`ifdef CALC_DIV_EN
        err_d      = (state_d == S_ERR);
`else
        err_d      = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'd0;
            res_q        <= '0;
            neg_q        <= 1'b0;
            disp_value_q <= '0;
            disp_neg_q   <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CALC_DIV_EN
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            neg_q        <= neg_d;
            disp_value_q <= disp_value_d;
            disp_neg_q   <= disp_neg_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
`ifdef CALC_DIV_EN
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign disp_value = disp_value_q;
    assign disp_neg   = disp_neg_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign op_code    = op_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Testbench for calc_entry_ctrl: directed scenarios plus random key streams against a behavioural model.
module tb_calc_entry_ctrl;

    localparam int RESW = 27;
`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int MA = 0, MOP = 1, MB = 2, MRES = 3, MERR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_valid = 1'b0;
    logic [4:0]      key_code = 5'd17;
    logic [RESW-1:0] disp_value;
    logic            disp_neg, err, busy;
    logic [1:0]      op_code;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode, m_a, m_b, m_op, m_res;

    calc_entry_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .disp_value(disp_value), .disp_neg(disp_neg), .err(err), .busy(busy), .op_code(op_code)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_mode = MA; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
    endfunction

    function automatic void model_key(input int c);
        if (c > 15) return;
        if (c == 15) begin model_clear(); return; end
        if (c <= 9) begin
            case (m_mode)
                MA:   if (m_a < 1000) m_a = m_a * 10 + c;
                MOP:  begin m_b = c; m_mode = MB; end
                MB:   if (m_b < 1000) m_b = m_b * 10 + c;
                MRES: begin m_a = c; m_mode = MA; end
                default: ;
            endcase
        end else if (c <= 12 || (c == 13 && DIV_EN)) begin
            if (m_mode == MA || m_mode == MOP) begin
                m_op = c - 10; m_mode = MOP;
            end else if (m_mode == MRES && m_res >= 0 && m_res <= 9999) begin
                m_a = m_res; m_op = c - 10; m_mode = MOP;
            end
        end else if (c == 14 && m_mode == MB) begin
            m_mode = MRES;
            case (m_op)
                0: m_res = m_a + m_b;
                1: m_res = m_a - m_b;
                2: m_res = m_a * m_b;
                default: if (m_b == 0) m_mode = MERR; else m_res = m_a / m_b;
            endcase
        end
    endfunction

    function automatic int exp_disp();
        case (m_mode)
            MA, MOP: return m_a;
            MB:      return m_b;
            MRES:    return (m_res < 0) ? -m_res : m_res;
            default: return 0;
        endcase
    endfunction

    task automatic press(input int c);
        key_valid = 1'b1;
        key_code  = 5'(c);
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_code  = 5'd17;
    endtask

    // Counts busy cycles until idle; optionally throws non-clear keys at the DUT while it is busy.
    task automatic wait_idle(input bit inject, output int cyc);
        int r;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (inject) begin
                r = $urandom_range(0, 31);
                if (r == 15) r = 14;
                key_valid = 1'b1;
                key_code  = 5'(r);
            end
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        key_code  = 5'd17;
        if (cyc >= 40) begin
            n_tests++; n_fail++;
            $display("FAIL busy_timeout got busy=%0b after %0d cycles exp idle", busy, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (disp_value !== '0) begin n_fail++; $display("FAIL reset_disp got=%0d exp=0", disp_value); end
        n_tests++; if (disp_neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got=%0b exp=0", disp_neg); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_tests++; if (op_code !== 2'd0) begin n_fail++; $display("FAIL reset_op got=%0d exp=0", op_code); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_entry();
        press(1); press(2); press(3);
        n_tests++; if (disp_value !== 27'd123) begin n_fail++; $display("FAIL entry_disp got=%0d exp=123", disp_value); end
        n_tests++; if (op_code !== 2'd0) begin n_fail++; $display("FAIL entry_op got=%0d exp=0", op_code); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL entry_err got=%0b exp=0", err); end
        press(17); press(22);
        n_tests++; if (disp_value !== 27'd123) begin n_fail++; $display("FAIL entry_nokey got=%0d exp=123", disp_value); end
    endtask

    task automatic test_add();
        int cyc;
        press(15); press(4); press(5); press(10); press(6); press(14);
        wait_idle(1'b0, cyc);
        n_tests++; if (cyc != 1) begin n_fail++; $display("FAIL add_busy_cycles got=%0d exp=1", cyc); end
        n_tests++; if (disp_value !== 27'd51) begin n_fail++; $display("FAIL add_disp got=%0d exp=51", disp_value); end
        n_tests++; if (disp_neg !== 1'b0) begin n_fail++; $display("FAIL add_neg got=%0b exp=0", disp_neg); end
    endtask

    task automatic test_sub();
        int cyc;
        press(15); press(3); press(11); press(8); press(14);
        wait_idle(1'b0, cyc);
        n_tests++; if (disp_value !== 27'd5) begin n_fail++; $display("FAIL sub_disp got=%0d exp=5", disp_value); end
        n_tests++; if (disp_neg !== 1'b1) begin n_fail++; $display("FAIL sub_neg got=%0b exp=1", disp_neg); end
        n_tests++; if (op_code !== 2'd1) begin n_fail++; $display("FAIL sub_op got=%0d exp=1", op_code); end
        press(10);
        n_tests++; if (disp_value !== 27'd5 || disp_neg !== 1'b1) begin n_fail++; $display("FAIL sub_op_ignored got=%0d/%0b exp=5/1", disp_value, disp_neg); end
        press(2);
        n_tests++; if (disp_value !== 27'd2 || disp_neg !== 1'b0) begin n_fail++; $display("FAIL sub_new_entry got=%0d/%0b exp=2/0", disp_value, disp_neg); end
    endtask

    task automatic test_mul();
        int cyc;
        press(15);
        repeat (5) press(9);
        n_tests++; if (disp_value !== 27'd9999) begin n_fail++; $display("FAIL mul_full_a got=%0d exp=9999", disp_value); end
        press(12);
        repeat (4) press(9);
        press(14);
        wait_idle(1'b0, cyc);
        n_tests++; if (disp_value !== 27'd99980001) begin n_fail++; $display("FAIL mul_disp got=%0d exp=99980001", disp_value); end
        press(10);
        n_tests++; if (disp_value !== 27'd99980001 || op_code !== 2'd2) begin n_fail++; $display("FAIL mul_big_chain got=%0d/%0d exp=99980001/2", disp_value, op_code); end
    endtask

`ifdef CALC_DIV_EN
    task automatic test_div();
        int cyc;
        press(15); press(1); press(0); press(0); press(13);
        n_tests++; if (op_code !== 2'd3) begin n_fail++; $display("FAIL div_op got=%0d exp=3", op_code); end
        press(7); press(14);
        wait_idle(1'b0, cyc);
        n_tests++; if (cyc != 15) begin n_fail++; $display("FAIL div_busy_cycles got=%0d exp=15", cyc); end
        n_tests++; if (disp_value !== 27'd14) begin n_fail++; $display("FAIL div_disp got=%0d exp=14", disp_value); end
        press(15); press(5); press(13); press(0); press(14);
        wait_idle(1'b0, cyc);
        n_tests++; if (err !== 1'b1 || disp_value !== '0) begin n_fail++; $display("FAIL div0 got err=%0b disp=%0d exp err=1 disp=0", err, disp_value); end
        n_tests++; if (cyc != 1) begin n_fail++; $display("FAIL div0_busy_cycles got=%0d exp=1", cyc); end
        press(5); press(10);
        n_tests++; if (err !== 1'b1 || disp_value !== '0) begin n_fail++; $display("FAIL div0_hold got err=%0b disp=%0d exp err=1 disp=0", err, disp_value); end
        press(15);
        n_tests++; if (err !== 1'b0 || disp_value !== '0) begin n_fail++; $display("FAIL div0_clear got err=%0b disp=%0d exp err=0 disp=0", err, disp_value); end
    endtask
`else
    task automatic test_div();
        int cyc;
        press(15); press(6); press(13);
        n_tests++; if (disp_value !== 27'd6 || op_code !== 2'd0) begin n_fail++; $display("FAIL nodiv_a got=%0d/%0d exp=6/0", disp_value, op_code); end
        press(10); press(13);
        n_tests++; if (op_code !== 2'd0) begin n_fail++; $display("FAIL nodiv_op got=%0d exp=0", op_code); end
        press(4); press(13); press(14);
        wait_idle(1'b0, cyc);
        n_tests++; if (disp_value !== 27'd10 || err !== 1'b0) begin n_fail++; $display("FAIL nodiv_sum got=%0d/%0b exp=10/0", disp_value, err); end
    endtask
`endif

    task automatic test_clear_busy();
        press(15); press(7); press(DIV_EN ? 13 : 12); press(2); press(14);
        if (DIV_EN) repeat (3) @(posedge clk);
        #0;
        press(15);
        n_tests++; if (busy !== 1'b0 || disp_value !== '0) begin n_fail++; $display("FAIL clear_busy got busy=%0b disp=%0d exp 0/0", busy, disp_value); end
        n_tests++; if (op_code !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL clear_busy_op got op=%0d err=%0b exp 0/0", op_code, err); end
        repeat (20) @(posedge clk);
        #1;
        n_tests++; if (disp_value !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_no_leak got disp=%0d busy=%0b exp 0/0", disp_value, busy); end
    endtask

    task automatic test_busy_drop();
        int cyc;
        press(15); press(1); press(0); press(0); press(DIV_EN ? 13 : 12); press(7); press(14);
        wait_idle(1'b1, cyc);
        n_tests++; if (cyc != (DIV_EN ? 15 : 1)) begin n_fail++; $display("FAIL drop_busy_cycles got=%0d exp=%0d", cyc, DIV_EN ? 15 : 1); end
        n_tests++; if (disp_value !== (DIV_EN ? 27'd14 : 27'd700)) begin n_fail++; $display("FAIL drop_disp got=%0d exp=%0d", disp_value, DIV_EN ? 14 : 700); end
    endtask

    task automatic test_async_reset();
        press(15); press(4); press(11); press(2);
        n_tests++; if (disp_value !== 27'd2 || op_code !== 2'd1) begin n_fail++; $display("FAIL pre_reset got=%0d/%0d exp=2/1", disp_value, op_code); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (disp_value !== '0 || op_code !== 2'd0 || busy !== 1'b0 || err !== 1'b0 || disp_neg !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got disp=%0d op=%0d busy=%0b err=%0b neg=%0b exp all 0", disp_value, op_code, busy, err, disp_neg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int r, c, cyc, exp_cyc;
        bit calc;
        press(15);
        model_clear();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 21);
            if (r <= 11)      c = r % 10;
            else if (r <= 15) c = r - 2;
            else if (r <= 18) c = 14;
            else if (r == 19) c = 15;
            else if (r == 20) c = 17;
            else              c = $urandom_range(16, 31);
            calc    = (m_mode == MB && c == 14);
            exp_cyc = (m_op == 3 && m_b != 0) ? 15 : 1;
            model_key(c);
            press(c);
            if (calc) begin
                wait_idle(1'($urandom_range(0, 1)), cyc);
                n_tests++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL rnd_busy step=%0d got=%0d exp=%0d", i, cyc, exp_cyc); end
            end else begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle step=%0d got busy=%0b exp=0", i, busy); end
            end
            n_tests++; if (disp_value !== RESW'(exp_disp())) begin n_fail++; $display("FAIL rnd_disp step=%0d key=%0d got=%0d exp=%0d", i, c, disp_value, exp_disp()); end
            n_tests++; if (disp_neg !== (m_mode == MRES && m_res < 0)) begin n_fail++; $display("FAIL rnd_neg step=%0d got=%0b exp=%0b", i, disp_neg, m_mode == MRES && m_res < 0); end
            n_tests++; if (err !== (m_mode == MERR)) begin n_fail++; $display("FAIL rnd_err step=%0d got=%0b exp=%0b", i, err, m_mode == MERR); end
            n_tests++; if (op_code !== 2'(m_op)) begin n_fail++; $display("FAIL rnd_op step=%0d got=%0d exp=%0d", i, op_code, m_op); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_entry();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_clear_busy();
        test_busy_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
